aes_mc_inv_column_scheduler: RTL and testbench
==============================================

Name: aes_mc_inv_column_scheduler

Overview:
- Sequences one time-shared `aes_mc_single_column_inverse` instance over a full 128-bit AES state, one column per cycle.
- Produces InvMixColumns of the whole state in 4 compute cycles.
- Sits between the InvSubBytes/InvShiftRows stage and AddRoundKey in an area-reduced decryption datapath.
- Valid/ready handshakes on both sides.

Parameters:
- NCOLS, 4, number of 32-bit columns per state (fixed at 4; any other value is illegal and flagged by an elaboration-time check).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input state valid.
- in_ready  output  1  block can accept a state.
- in_data  input  128  input state; column c = in_data[32*c +: 32]; byte r of column at bits [8*r +: 8].
- out_valid  output  1  result state valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  128  InvMixColumns(in_data); same column/byte layout.
- busy  output  1  high while a column computation is in progress (state BUSY).

Behaviour:
- Storage: one 128-bit working register `st`, a 2-bit column counter `col`, and a 2-bit FSM register.
- FSM states: IDLE, BUSY, DONE.
- Reset (rst=1 at an edge): FSM=IDLE, col=0, st=0.
  - Outputs after reset: in_ready=1, out_valid=0, busy=0, out_data=0.
  - Reset overrides any handshake in the same cycle, including mid-computation; the partial state is discarded.
- in_ready = (FSM==IDLE) | (FSM==DONE & out_ready). Combinational; no dependency on in_valid.
- out_valid = (FSM==DONE). out_data = st at all times.
- busy = (FSM==BUSY).
- IDLE:
  - On in_valid&in_ready: st<=in_data, col<=0, FSM->BUSY.
  - Otherwise hold.
- BUSY:
  - Single inverse-column instance input = st[32*col +: 32].
  - Each cycle: st[32*col +: 32] <= instance output; col <= col+1 (2-bit wrap).
  - When col==3: FSM->DONE, col wraps to 0.
  - in_valid is ignored (in_ready=0).
- DONE:
  - Result is held stable while out_ready=0; in_ready=0 in that case.
  - out_valid&out_ready with in_valid=0: FSM->IDLE; st holds its value.
  - out_valid&out_ready with in_valid=1 in the same cycle: back-to-back. st<=in_data, col<=0, FSM->BUSY.
- Latency: input handshake at edge T; columns 0..3 written at edges T+1..T+4; out_valid=1 from edge T+4.
- Throughput: 1 state per 5 cycles with back-to-back handshakes.
- The arithmetic is purely combinational inside the instance; the scheduler adds no GF(2^8) logic.
- AXI-stream-like rule: once out_valid is asserted, out_data does not change until the output handshake.

Optional Feature:
- Macro: SMAESH_MC_INV_BYPASS_EN.
- Defined:
  - Adds input port `in_bypass` (1 bit), sampled with the input handshake into a flag register (reset 0).
  - If the flag is set, BUSY writes st back unchanged (the instance output is ignored), so out_data==in_data. This serves the last decryption round, which has no InvMixColumns.
  - Timing and latency are identical (still 4 BUSY cycles) so the schedule stays data-independent.
- Undefined:
  - No `in_bypass` port and no flag register.
  - InvMixColumns is always applied.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 → in_ready=1, out_valid=0, busy=0, out_data=0; no state accepted.
- Single state, FIPS vectors: in_data = {0x01010101, 0xc6c6c6c6, 0x9d58dc9f, 0xbca14d8e} (column 3..0) → out_data = {0x01010101, 0xc6c6c6c6, 0x5c220af2, 0x455313db}.
  - out_valid rises exactly 4 cycles after the input handshake.
  - busy is high for exactly 4 cycles.
- Backpressure: out_ready=0 for 10 cycles after DONE → out_valid stays 1, out_data stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 and a new state → same-cycle back-to-back accept; the next result arrives 4 cycles later.
- Mid-operation reset: assert rst at the 2nd BUSY cycle → next cycle IDLE, out_valid=0, st=0.
  - A following state of all zeros yields out_data=0 with normal latency.
- Stream of 8 random states with random out_ready throttling → results match a reference InvMixColumns model in order; no drops or duplicates.
- With SMAESH_MC_INV_BYPASS_EN: in_bypass=1, in_data=0x00112233445566778899aabbccddeeff → out_data identical, latency 4.
  - Then in_bypass=0 with the FIPS vector above → correct InvMixColumns result.

Source files
------------

// File: rtl/aes_mc_inv_column_scheduler.sv
// aes_mc_inv_column_scheduler
// Applies InvMixColumns to a 128-bit AES state by time-sharing one
// single-column inverse unit over the four columns, one column per cycle.
// Column c sits at bits [32*c +: 32]. Byte r of a column sits at bits [8*r +: 8].
// Optional feature macro: SMAESH_MC_INV_BYPASS_EN. When it is defined, the
// in_bypass input is added. A state accepted with in_bypass=1 is returned
// unchanged after the same 4-cycle schedule. The last decryption round uses
// this because it has no InvMixColumns.

// Purely combinational InvMixColumns of one 32-bit column.
// b[r] = 0e*a[r] ^ 0b*a[r+1] ^ 0d*a[r+2] ^ 09*a[r+3]   (indices mod 4)
module aes_mc_single_column_inverse (
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);
    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] m09 [4];
    logic [7:0] m0b [4];
    logic [7:0] m0d [4];
    logic [7:0] m0e [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mul
            logic [7:0] a, x2, x4, x8;
            assign a  = col_in[8*gi +: 8];
            assign x2 = xtime(a);
            assign x4 = xtime(x2);
            assign x8 = xtime(x4);
            assign m09[gi] = x8 ^ a;
            assign m0b[gi] = x8 ^ x2 ^ a;
            assign m0d[gi] = x8 ^ x4 ^ a;
            assign m0e[gi] = x8 ^ x4 ^ x2;
        end

        for (gi = 0; gi < 4; gi++) begin : g_row
            assign col_out[8*gi +: 8] = m0e[gi] ^ m0b[(gi+1)%4]
                                      ^ m0d[(gi+2)%4] ^ m09[(gi+3)%4];
        end
    endgenerate
endmodule

module aes_mc_inv_column_scheduler #(
    parameter int NCOLS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
`ifdef SMAESH_MC_INV_BYPASS_EN
    input  logic         in_bypass,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    // The column counter and the state width are sized for exactly four columns.
    generate
        if (NCOLS != 4) begin : g_bad_ncols
            $error("aes_mc_inv_column_scheduler: NCOLS must be 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_reg;
    logic [1:0]   col_reg;
    logic [127:0] st_reg;
    logic [31:0]  col_sel;
    logic [31:0]  col_mc;
    logic [31:0]  col_result;
    logic         accept;

`ifdef SMAESH_MC_INV_BYPASS_EN
    logic         bypass_reg;
`endif

    // The only GF(2^8) logic in the datapath. It is shared by all four columns.
    aes_mc_single_column_inverse u_col (
        .col_in  (col_sel),
        .col_out (col_mc)
    );

    // Handshake and status outputs are decoded from the FSM register.
    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == BUSY);
    assign out_data  = st_reg;
    assign accept    = in_valid && in_ready;

    // Select the column that is processed in this cycle.
    assign col_sel = st_reg[32*col_reg +: 32];

`ifdef SMAESH_MC_INV_BYPASS_EN
    // A bypassed state writes its own columns back, so the schedule stays
    // the same and only the data path differs.
    assign col_result = bypass_reg ? col_sel : col_mc;
`else
    assign col_result = col_mc;
`endif

    // FSM plus the working state: load on accept, fold in one column per BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            col_reg    <= 2'd0;
            st_reg     <= '0;
`ifdef SMAESH_MC_INV_BYPASS_EN
            bypass_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (accept) begin
                        st_reg     <= in_data;
                        col_reg    <= 2'd0;
                        state_reg  <= BUSY;
`ifdef SMAESH_MC_INV_BYPASS_EN
                        bypass_reg <= in_bypass;
`endif
                    end else if ((state_reg == DONE) && out_ready) begin
                        // Result consumed and there is no new state. Keep st as it is.
                        state_reg <= IDLE;
                    end
                end
                BUSY: begin
                    st_reg[32*col_reg +: 32] <= col_result;
                    col_reg                  <= col_reg + 2'd1;
                    if (col_reg == 2'd3) begin
                        state_reg <= DONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    col_reg   <= 2'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_mc_inv_column_scheduler.sv
// Testbench for aes_mc_inv_column_scheduler.
// Stimulus pushes expected results into a scoreboard queue.
// A negedge monitor pops an entry and compares it on every output handshake.
module tb_aes_mc_inv_column_scheduler;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic         rand_ready = 1'b0;
    logic         rnd_ready  = 1'b1;
    logic         fixed_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_push   = 0;
    int n_pop    = 0;
    logic [127:0] sb[$];

    localparam logic [127:0] FIPS_IN  = 128'h01010101_c6c6c6c6_9d58dc9f_bca14d8e;
    localparam logic [127:0] FIPS_OUT = 128'h01010101_c6c6c6c6_5c220af2_455313db;

    assign out_ready = rand_ready ? rnd_ready : fixed_ready;

    always #5 clk = ~clk;

    aes_mc_inv_column_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef SMAESH_MC_INV_BYPASS_EN
        .in_bypass (in_bypass),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // GF(2^8) product computed by plain shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Reference InvMixColumns: the circulant matrix (0e 0b 0d 09) times each column.
    function automatic logic [127:0] inv_mc_ref(input logic [127:0] s, input logic byp);
        logic [7:0]   coef [4];
        logic [127:0] r = '0;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        if (byp) return s;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                logic [7:0] acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc ^= gmul(s[32*c + 8*k +: 8], coef[(k - row + 4) % 4]);
                r[32*c + 8*row +: 8] = acc;
            end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Throttling of out_ready during the random stream.
    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 1) == 1);
    end

    // Monitor: checks the scoreboard on each output handshake and checks
    // that a result under backpressure stays stable.
    logic         held_valid = 1'b0;
    logic [127:0] held_data  = '0;
    always @(negedge clk) begin
        if (rst) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid && out_valid)
                chk("out_data_hold", out_data, held_data);
            held_valid = out_valid && !out_ready;
            held_data  = out_data;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", out_data, 128'hx);
                end else begin
                    logic [127:0] e;
                    e = sb.pop_front();
                    n_pop++;
                    chk("result", out_data, e);
                    $display("out: %h exp %h", out_data, e);
                end
            end
        end
    end

    // Drive one state until it is accepted, then push its expected result.
    task automatic send(input logic [127:0] d, input logic byp, input logic use_exp,
                        input logic [127:0] exp);
        int waited = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_bypass = byp;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                chk("in_ready_timeout", 128'(in_ready), 128'd1);
                break;
            end
            @(posedge clk); #1;
        end
        sb.push_back(use_exp ? exp : inv_mc_ref(d, byp));
        n_push++;
        $display("in:  %h bypass=%0d", d, byp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Runs just after the accepting edge. It counts cycles until out_valid
    // and counts the busy cycles in that interval.
    task automatic check_latency(input string tag);
        int cyc = 0;
        int bcnt = 0;
        forever begin
            @(negedge clk);
            if (busy) begin
                bcnt++;
                chk({tag, "_in_ready_busy"}, 128'(in_ready), 128'd0);
            end
            if (out_valid || cyc > 30) break;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 128'(cyc), 128'd4);
        chk({tag, "_busy_cycles"}, 128'(bcnt), 128'd4);
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        int w = 0;
        rand_ready  = 1'b0;
        fixed_ready = 1'b1;
        while (sb.size() != 0 && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        chk({tag, "_drained"}, 128'(sb.size()), 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
        in_bypass = 1'b0;
        // Reset held for 2 cycles while a state is offered.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 128'(busy), 128'd0);

        // FIPS vector with the output initially blocked.
        @(posedge clk); #1;
        send(FIPS_IN, 1'b0, 1'b1, FIPS_OUT);
        check_latency("fips");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_out_data", out_data, FIPS_OUT);
            @(posedge clk); #1;
        end
        // Back-to-back: release the result and accept a new state on the same edge.
        fixed_ready = 1'b1;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, '0);
        check_latency("b2b");
        drain("b2b");

        // Reset during the second BUSY cycle discards the partial result.
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_back());
        n_push--;
        @(negedge clk);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_out_data", out_data, 128'd0);
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        send(128'd0, 1'b0, 1'b1, 128'd0);
        check_latency("zero");
        drain("zero");

        // Random stream with random output throttling.
        rand_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, '0);
        end
        drain("stream");

`ifdef SMAESH_MC_INV_BYPASS_EN
        send(128'h00112233445566778899aabbccddeeff, 1'b1, 1'b1,
             128'h00112233445566778899aabbccddeeff);
        check_latency("bypass");
        send(FIPS_IN, 1'b0, 1'b1, FIPS_OUT);
        check_latency("after_bypass");
        drain("bypass");
`endif

        chk("push_pop_count", 128'(n_pop), 128'(n_push));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
